stream_demux_1to2: RTL
======================

# stream_demux_1to2

Two-way stream demultiplexer with per-port buffering: routes each 32-bit input word to one of two output streams by a select bit, with valid/ready handshakes on all sides. It is the distributing counterpart of the datapath's 2:1 select mux. The select encoding is the same: sel=0 maps to port 1 and sel=1 maps to port 2. Each output has its own small FIFO, so a stalled consumer on one port does not block traffic bound for the other port unless that port's FIFO is full.

## Interface
- DATA_WIDTH, 32, width of data words
- FIFO_DEPTH, 2, entries per output FIFO; power of two, ≥2
- CNT_WIDTH, 16, width of per-port accepted-word counters
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- in_data  input  DATA_WIDTH  input word
- in_sel  input  1  destination: 0 → port 1, 1 → port 2; qualified by in_valid
- in_valid  input  1  in_data/in_sel valid
- in_ready  output  1  block can accept a word for the port named by in_sel
- out1_data  output  DATA_WIDTH  head word of port-1 FIFO
- out1_valid  output  1  port-1 FIFO non-empty
- out1_ready  input  1  port-1 consumer accepts head word
- out2_data, out2_valid, out2_ready  same as port 1, for port 2
- cnt1, cnt2  output  CNT_WIDTH  words accepted into port 1 / port 2 since reset

## Operation
- Accept condition: in_valid && in_ready. On acceptance, in_data is written to the FIFO chosen by in_sel.
- in_ready = !full[in_sel]. This is combinational from in_sel and the FIFO occupancy. in_ready does not depend on in_valid or on either out*_ready.
- Full FIFO: no pass-through. A full FIFO refuses the write even if its consumer pops in the same cycle; the freed slot is usable from the next cycle.
- Pop condition per port: outN_valid && outN_ready. A pop advances the read pointer.
- Simultaneous push and pop on the same non-full FIFO: both take effect and occupancy is unchanged. Pushing one port while popping the other: each FIFO updates independently.
- Empty-FIFO push is not visible in the same cycle. The word appears on outN_data/outN_valid the following cycle.
- outN_valid = (occupancy != 0). outN_data = word at the read pointer when valid; it is driven 0 when outN_valid = 0.
- Read and write pointers are log2(FIFO_DEPTH)+1 bits. Full is detected when the addresses are equal and the wrap bits differ. Empty is detected when the pointers are equal. Pointers wrap naturally.
- Ordering: words leave each port in acceptance order. There is no ordering guarantee across the two ports.
- Counters: cntN increments by 1 on each acceptance to port N. It wraps modulo 2^CNT_WIDTH (0xFFFF → 0x0000), and the wrap is silent. Counters do not change on pop.
- in_sel and in_data are ignored when in_valid = 0.

## Timing
- Reset (reset=1 at a rising edge) clears all pointers and both counters, so both FIFOs are empty. After that edge: out1_valid = out2_valid = 0, out1_data = out2_data = 0, cnt1 = cnt2 = 0, in_ready = 1.
- Reset applied mid-operation discards all buffered words in the same edge. Any handshake presented during the reset cycle is ignored, and no counter increments.
- Latency from input acceptance to outN_valid is 1 cycle.
- Throughput per port is 1 word/cycle when outN_ready is held high. The input sustains 1 word/cycle while the targeted FIFO is not full.
- A FIFO holds FIFO_DEPTH words before deasserting in_ready for that port.
- No combinational path exists from outN_ready to in_ready or to outN_data.

## Test plan
- Reset then idle: assert reset 2 cycles, release → out1_valid=out2_valid=0, out*_data=0, cnt1=cnt2=0, in_ready=1.
- Routing: send 0xA5A5_0001 (sel=0) then 0x5A5A_0002 (sel=1), both ready high → out1 shows 0xA5A5_0001 one cycle after its acceptance. out2 shows 0x5A5A_0002 one cycle after its own. cnt1=1, cnt2=1.
- Backpressure isolation: out1_ready=0, out2_ready=1; send 3 words with sel=0 → the first 2 are accepted, then in_ready=0 with sel=0. Present sel=1 with 0x0000_00B2 → in_ready=1, and the word appears on out2. Raise out1_ready → out1 delivers the first two words in order. The third word is accepted on the cycle after the first pop.
- Full with simultaneous pop: fill port 2 (0x11, 0x22), hold sel=1 valid with 0x33, pulse out2_ready one cycle → 0x33 is not accepted that cycle and is accepted on the next cycle. Output order is 0x11, 0x22, 0x33.
- Counter wrap: preload via 65535 accepted sel=0 words, send one more → cnt1 goes 0xFFFF → 0x0000. cnt2 is unchanged.
- Reset mid-stream: with port 1 holding 2 words and port 2 holding 1 word, assert reset while in_valid=1 → next cycle all valids are 0, counters are 0, and the offered word is not counted or delivered.

Source files
------------

// File: rtl/stream_demux_1to2.sv
// stream_demux_1to2
//   Two-way stream demultiplexer. Each accepted input word is routed by
//   in_sel (0 -> port 1, 1 -> port 2) into that port's private FIFO, so a
//   stalled consumer only blocks traffic bound for its own port.
//
// Ports
//   clk, reset            single clock, synchronous active-high reset
//   in_data/in_sel/in_valid/in_ready     input stream with destination select
//   out1_data/out1_valid/out1_ready      port-1 output stream (FIFO head)
//   out2_data/out2_valid/out2_ready      port-2 output stream (FIFO head)
//   cnt1, cnt2            words accepted per port since reset (wrapping)
module stream_demux_1to2 #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_sel,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out1_data,
    output logic                  out1_valid,
    input  logic                  out1_ready,
    output logic [DATA_WIDTH-1:0] out2_data,
    output logic                  out2_valid,
    input  logic                  out2_ready,
    output logic [CNT_WIDTH-1:0]  cnt1,
    output logic [CNT_WIDTH-1:0]  cnt2
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    typedef logic [AW:0] ptr_t;
    typedef logic [CNT_WIDTH-1:0] cnt_t;

    localparam ptr_t PTR_ONE = ptr_t'(1);
    localparam cnt_t CNT_ONE = cnt_t'(1);

    ptr_t                  wr_ptr [2];
    ptr_t                  rd_ptr [2];
    cnt_t                  cnt    [2];
    logic [DATA_WIDTH-1:0] mem    [2][FIFO_DEPTH];

    logic [1:0] full;
    logic [1:0] empty;
    logic [1:0] push;
    logic [1:0] pop;
    logic [1:0] out_ready;
    logic       accept;

    always_comb begin
        full  = '0;
        empty = '0;
        for (int unsigned p = 0; p < 2; p++) begin
            full[p]  = (wr_ptr[p][AW-1:0] == rd_ptr[p][AW-1:0]) &&
                       (wr_ptr[p][AW] != rd_ptr[p][AW]);
            empty[p] = (wr_ptr[p] == rd_ptr[p]);
        end
    end

    // Readiness depends only on the selected FIFO's occupancy; a pop in the
    // same cycle does not free the slot until the next cycle.
    assign in_ready  = !full[in_sel];
    assign accept    = in_valid && in_ready;
    assign push      = {accept && in_sel, accept && !in_sel};
    assign out_ready = {out2_ready, out1_ready};
    assign pop       = ~empty & out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned p = 0; p < 2; p++) begin
                wr_ptr[p] <= '0;
                rd_ptr[p] <= '0;
                cnt[p]    <= '0;
            end
        end else begin
            for (int unsigned p = 0; p < 2; p++) begin
                if (push[p]) begin
                    wr_ptr[p] <= wr_ptr[p] + PTR_ONE;
                    cnt[p]    <= cnt[p] + CNT_ONE;
                end
                if (pop[p]) begin
                    rd_ptr[p] <= rd_ptr[p] + PTR_ONE;
                end
            end
        end
    end

    // Storage needs no reset: reset empties the FIFOs via the pointers, and
    // a write during reset lands in a slot that is already considered free.
    always_ff @(posedge clk) begin
        for (int unsigned p = 0; p < 2; p++) begin
            if (push[p]) begin
                mem[p][wr_ptr[p][AW-1:0]] <= in_data;
            end
        end
    end

    always_comb begin
        out1_valid = !empty[0];
        out2_valid = !empty[1];
        out1_data  = '0;
        out2_data  = '0;
        if (!empty[0]) begin
            out1_data = mem[0][rd_ptr[0][AW-1:0]];
        end
        if (!empty[1]) begin
            out2_data = mem[1][rd_ptr[1][AW-1:0]];
        end
    end

    assign cnt1 = cnt[0];
    assign cnt2 = cnt[1];

endmodule
